// File: rtl/reg_wr_mux_if.sv
// Request / result bundle between the decoder side and the register-bank write port.
interface reg_wr_mux_if #(
  parameter int PA_SRC_N = 4,
  parameter int PA_SEL   = 3,
  parameter int PA_DATA  = 32,
  parameter int PA_IMME  = 16,
  parameter int PA_ADDR  = 5
);
  logic                         in_valid;
  logic                         in_ready;
  logic [PA_SEL-1:0]            ip_sel;
  logic [2:0]                   imm_mode;
  logic [PA_ADDR-1:0]           dst_addr;
  logic [PA_SRC_N*PA_DATA-1:0]  src_bus;
  logic [PA_IMME-1:0]           id_imme;
  logic [PA_DATA-1:0]           cur_val;
  logic                         out_valid;
  logic                         out_ready;
  logic [PA_ADDR-1:0]           out_addr;
  logic [PA_DATA-1:0]           out_data;
  logic                         pend;
  logic                         err;

  modport master (
    output in_valid, ip_sel, imm_mode, dst_addr, src_bus, id_imme, cur_val, out_ready,
    input  in_ready, out_valid, out_addr, out_data, pend, err
  );

  modport slave (
    input  in_valid, ip_sel, imm_mode, dst_addr, src_bus, id_imme, cur_val, out_ready,
    output in_ready, out_valid, out_addr, out_data, pend, err
  );
endinterface

// File: rtl/reg_wr_mux.sv
// Write-data source mux for the register bank: picks a bus or builds an immediate,
// tags it with the destination address and queues it in a 2-entry FIFO.
//
// state | meaning
// IDLE  | no low half held for a two-beat immediate
// HOLD  | low half captured by an assemble-low beat, waiting for assemble-high
module reg_wr_mux #(
  parameter int PA_SRC_N = 4,
  parameter int PA_SEL   = 3,
  parameter int PA_DATA  = 32,
  parameter int PA_IMME  = 16,
  parameter int PA_ADDR  = 5
) (
  input logic       clk,
  input logic       rst,
  reg_wr_mux_if.slave bus
);
  localparam int H = PA_IMME;
  localparam logic [PA_SEL-1:0] SEL_IMM = PA_SEL'(PA_SRC_N + 1);

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t                     state;
  logic                       pend_q;
  logic                       err_q;
  logic [PA_IMME-1:0]         hold_q;
  logic [PA_ADDR+PA_DATA-1:0] mem [2];
  logic                       rd_ptr;
  logic                       wr_ptr;
  logic [1:0]                 count;

  logic                       accept;
  logic                       pop;
  logic                       push_c;
  logic                       push_fire;
  logic                       err_c;
  logic                       load_hold_c;
  logic                       assemble_c;
  logic [PA_DATA-1:0]         data_c;

  // Full FIFO refuses a push even when the head drains in the same cycle.
  assign bus.in_ready = (count != 2'd2);
  assign accept       = bus.in_valid & bus.in_ready;
  assign pop          = (count != 2'd0) & bus.out_ready;
  assign push_fire    = accept & push_c;

  assign bus.out_valid                = (count != 2'd0);
  assign {bus.out_addr, bus.out_data} = mem[rd_ptr];
  assign bus.pend                     = pend_q;
  assign bus.err                      = err_q;

  // Source select and immediate construction for the word offered this cycle.
  always_comb begin
    push_c      = 1'b1;
    err_c       = 1'b0;
    load_hold_c = 1'b0;
    assemble_c  = 1'b0;
    data_c      = '0;
    if (bus.ip_sel == SEL_IMM) begin
      case (bus.imm_mode)
        3'b000: data_c = {{H{1'b0}}, bus.id_imme};
        3'b001: data_c = {{H{bus.id_imme[H-1]}}, bus.id_imme};
        3'b010: data_c = {bus.id_imme, {H{1'b0}}};
        3'b011: data_c = {bus.id_imme, bus.cur_val[H-1:0]};
        3'b100: data_c = {bus.cur_val[PA_DATA-1:H], bus.id_imme};
        3'b101: begin
          push_c      = 1'b0;
          load_hold_c = 1'b1;
        end
        3'b110: begin
          assemble_c = 1'b1;
          if (state == ST_HOLD) begin
            data_c = {bus.id_imme, hold_q};
          end else begin
            data_c = {bus.id_imme, {H{1'b0}}};
            err_c  = 1'b1;
          end
        end
        default: err_c = 1'b1;
      endcase
    end else if (bus.ip_sel != '0) begin
      // Unmapped selects fall through with zero data and an error flag.
      err_c = 1'b1;
      for (int k = 0; k < PA_SRC_N; k++) begin
        if (bus.ip_sel == PA_SEL'(k + 1)) begin
          data_c = bus.src_bus[k*PA_DATA +: PA_DATA];
          err_c  = 1'b0;
        end
      end
    end
  end

  // Two-beat immediate tracker; other traffic passes without leaving HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      pend_q <= 1'b0;
      hold_q <= '0;
    end else if (accept && load_hold_c) begin
      state  <= ST_HOLD;
      pend_q <= 1'b1;
      hold_q <= bus.id_imme;
    end else if (accept && assemble_c) begin
      state  <= ST_IDLE;
      pend_q <= 1'b0;
    end
  end

  // Error flag is a single-cycle pulse after the offending accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept & err_c;
    end
  end

  // Two-entry FIFO; the head slot is never written while it is occupied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push_fire) begin
        mem[wr_ptr] <= {bus.dst_addr, data_c};
        wr_ptr      <= ~wr_ptr;
      end
      count <= count + {1'b0, push_fire} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_reg_wr_mux.sv
// Directed plus randomized bench for reg_wr_mux with a queue-based reference model.
module tb_reg_wr_mux;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [127:0] src;
  logic [36:0]  q[$];
  bit           m_pend;
  bit           m_err;
  logic [15:0]  m_hold;

  reg_wr_mux_if #(.PA_SRC_N(4), .PA_SEL(3), .PA_DATA(32), .PA_IMME(16), .PA_ADDR(5)) bus ();

  reg_wr_mux #(.PA_SRC_N(4), .PA_SEL(3), .PA_DATA(32), .PA_IMME(16), .PA_ADDR(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, q.size() != 2});
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() != 0});
    chk("pend", {31'b0, bus.pend}, {31'b0, m_pend});
    chk("err", {31'b0, bus.err}, {31'b0, m_err});
    if (q.size() != 0) begin
      chk("out_addr", {27'b0, bus.out_addr}, {27'b0, q[0][36:32]});
      chk("out_data", bus.out_data, q[0][31:0]);
    end
  endtask

  // Reference: what the bank should receive, straight from the mode table.
  task automatic model(input bit v, input int sel, input int mode, input logic [4:0] addr,
                       input logic [15:0] imme, input logic [31:0] cur, input bit rdy);
    bit          acc;
    bit          popf;
    bit          push;
    bit          e;
    logic [31:0] d;
    acc  = v && (q.size() < 2);
    popf = rdy && (q.size() > 0);
    push = 1'b1;
    e    = 1'b0;
    d    = 32'h0;
    if (sel == 0) begin
      d = 32'h0;
    end else if (sel <= 4) begin
      d = 32'(src >> (32 * (sel - 1)));
    end else if (sel == 5) begin
      case (mode)
        0: d = 32'(imme);
        1: d = 32'($signed(imme));
        2: d = 32'(imme) << 16;
        3: d = (32'(imme) << 16) | (cur & 32'h0000FFFF);
        4: d = (cur & 32'hFFFF0000) | 32'(imme);
        5: begin
          push = 1'b0;
          if (acc) begin
            m_hold = imme;
            m_pend = 1'b1;
          end
        end
        6: begin
          d = (32'(imme) << 16) | (m_pend ? 32'(m_hold) : 32'h0);
          e = !m_pend;
          if (acc) m_pend = 1'b0;
        end
        default: e = 1'b1;
      endcase
    end else begin
      e = 1'b1;
    end
    if (popf) void'(q.pop_front());
    if (acc && push) q.push_back({addr, d});
    m_err = acc && e;
  endtask

  task automatic cyc(input bit v, input int sel, input int mode, input logic [4:0] addr,
                     input logic [15:0] imme, input logic [31:0] cur, input bit rdy);
    bus.in_valid  = v;
    bus.ip_sel    = 3'(sel);
    bus.imm_mode  = 3'(mode);
    bus.dst_addr  = addr;
    bus.id_imme   = imme;
    bus.cur_val   = cur;
    bus.src_bus   = src;
    bus.out_ready = rdy;
    model(v, sel, mode, addr, imme, cur, rdy);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_pend = 1'b0;
    m_err  = 1'b0;
    m_hold = 16'h0;
    src    = {$urandom, $urandom, $urandom, $urandom};
    rst    = 1'b1;
    bus.in_valid  = 1'b0;
    bus.ip_sel    = '0;
    bus.imm_mode  = '0;
    bus.dst_addr  = '0;
    bus.id_imme   = '0;
    bus.cur_val   = '0;
    bus.src_bus   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_out_addr", {27'b0, bus.out_addr}, 32'h0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_pend", {31'b0, bus.pend}, 32'h0);
    chk("rst_err", {31'b0, bus.err}, 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);

    // Bus source 1 selected by sel=2.
    src[32 +: 32] = 32'hDEADBEEF;
    cyc(1, 2, 0, 5'd3, 16'h0, 32'h0, 1);
    chk("t1_data", bus.out_data, 32'hDEADBEEF);
    chk("t1_addr", {27'b0, bus.out_addr}, 32'd3);

    // Sign-extend and merge-upper, each replacing the head via push+pop.
    cyc(1, 5, 1, 5'd4, 16'h8001, 32'h0, 1);
    chk("t2_sext", bus.out_data, 32'hFFFF8001);
    cyc(1, 5, 3, 5'd5, 16'h1234, 32'hAAAA5555, 1);
    chk("t2_merge_hi", bus.out_data, 32'h12345555);
    cyc(1, 5, 4, 5'd6, 16'h9876, 32'hAAAA5555, 1);
    chk("t2_merge_lo", bus.out_data, 32'hAAAA9876);

    // Two-beat assembly with an unrelated beat in between.
    cyc(0, 0, 0, 5'd0, 16'h0, 32'h0, 1);
    cyc(1, 5, 5, 5'd7, 16'hBEEF, 32'h0, 1);
    chk("t3_pend", {31'b0, bus.pend}, 32'h1);
    chk("t3_nopush", {31'b0, bus.out_valid}, 32'h0);
    src[31:0] = 32'h01020304;
    cyc(1, 1, 6, 5'd8, 16'h5555, 32'h0, 1);
    chk("t3_pass_pend", {31'b0, bus.pend}, 32'h1);
    cyc(1, 5, 6, 5'd9, 16'hCAFE, 32'h0, 1);
    chk("t3_asm", bus.out_data, 32'hCAFEBEEF);
    chk("t3_asm_addr", {27'b0, bus.out_addr}, 32'd9);
    chk("t3_pend_clr", {31'b0, bus.pend}, 32'h0);

    // Back-pressure: two accepted, third refused, then drain in order.
    cyc(0, 0, 0, 5'd0, 16'h0, 32'h0, 1);
    cyc(1, 5, 0, 5'd10, 16'h0011, 32'h0, 0);
    cyc(1, 5, 0, 5'd11, 16'h0022, 32'h0, 0);
    cyc(1, 5, 0, 5'd12, 16'h0033, 32'h0, 0);
    chk("t4_full", {31'b0, bus.in_ready}, 32'h0);
    chk("t4_head", bus.out_data, 32'h00000011);
    cyc(0, 0, 0, 5'd0, 16'h0, 32'h0, 1);
    chk("t4_second", bus.out_data, 32'h00000022);
    cyc(0, 0, 0, 5'd0, 16'h0, 32'h0, 1);

    // Error cases: unmapped select and assemble-high without a held low half.
    cyc(1, 7, 0, 5'd13, 16'hFFFF, 32'h0, 1);
    chk("t5_sel_err", {31'b0, bus.err}, 32'h1);
    chk("t5_sel_data", bus.out_data, 32'h0);
    cyc(1, 5, 6, 5'd14, 16'h4321, 32'h0, 1);
    chk("t5_asm_err", {31'b0, bus.err}, 32'h1);
    chk("t5_asm_data", bus.out_data, 32'h43210000);
    cyc(1, 5, 7, 5'd15, 16'h1111, 32'h0, 1);
    chk("t5_rsvd_data", bus.out_data, 32'h0);
    cyc(0, 0, 0, 5'd0, 16'h0, 32'h0, 1);
    chk("t5_err_pulse", {31'b0, bus.err}, 32'h0);

    // Async reset while full and holding a low half.
    cyc(1, 5, 5, 5'd1, 16'hAAAA, 32'h0, 0);
    cyc(1, 2, 0, 5'd2, 16'h0, 32'h0, 0);
    cyc(1, 3, 0, 5'd3, 16'h0, 32'h0, 0);
    chk("t6_full", {31'b0, bus.in_ready}, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("t6_pend", {31'b0, bus.pend}, 32'h0);
    q.delete();
    m_pend = 1'b0;
    m_err  = 1'b0;
    m_hold = 16'h0;
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 5, 6, 5'd4, 16'h7777, 32'h0, 1);
    chk("t6_hold_gone", bus.out_data, 32'h77770000);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      src = {$urandom, $urandom, $urandom, $urandom};
      cyc(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
          ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 6)) : int'($urandom_range(0, 7)),
          5'($urandom), 16'($urandom), $urandom, bit'($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
